// File: rtl/mem_wb_unit_pkg.sv
// ============================================================================
// mem_wb_unit_pkg : shared widths, memory-op encodings, FSM states, helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_wb_unit_pkg;

    localparam int REG_LEN      = 32;
    localparam int REG_ADDR_LEN = 5;
    localparam int MEM_OP_W     = 4;

    localparam logic [REG_LEN-1:0]      ZERO_WORD = '0;
    localparam logic [REG_ADDR_LEN-1:0] X0        = '0;

    localparam logic [MEM_OP_W-1:0] MEM_NONE = 4'd0;
    localparam logic [MEM_OP_W-1:0] MEM_LB   = 4'd1;
    localparam logic [MEM_OP_W-1:0] MEM_LH   = 4'd2;
    localparam logic [MEM_OP_W-1:0] MEM_LW   = 4'd3;
    localparam logic [MEM_OP_W-1:0] MEM_LBU  = 4'd4;
    localparam logic [MEM_OP_W-1:0] MEM_LHU  = 4'd5;
    localparam logic [MEM_OP_W-1:0] MEM_SB   = 4'd6;
    localparam logic [MEM_OP_W-1:0] MEM_SH   = 4'd7;
    localparam logic [MEM_OP_W-1:0] MEM_SW   = 4'd8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_LOAD_TAIL = 2'd2;
    localparam logic [1:0] ST_STORE     = 2'd3;

    function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Index of the last byte moved by an access (access length minus one).
    function automatic logic [1:0] mem_op_last(input logic [MEM_OP_W-1:0] op);
        logic [1:0] last;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: last = 2'd0;
            MEM_LH, MEM_LHU, MEM_SH: last = 2'd1;
            default:                 last = 2'd3;
        endcase
        return last;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_unit_load_extend.sv
// ============================================================================
// mem_wb_unit_load_extend : sign/zero-extends assembled load bytes per op
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_wb_unit_load_extend
    import mem_wb_unit_pkg::*;
(
    input  logic [REG_LEN-1:0]  bytes_i,
    input  logic [MEM_OP_W-1:0] op_i,
    output logic [REG_LEN-1:0]  value_o
);

    always_comb begin
        value_o = bytes_i;
        case (op_i)
            MEM_LB:  value_o = {{24{bytes_i[7]}}, bytes_i[7:0]};
            MEM_LBU: value_o = {24'd0, bytes_i[7:0]};
            MEM_LH:  value_o = {{16{bytes_i[15]}}, bytes_i[15:0]};
            MEM_LHU: value_o = {16'd0, bytes_i[15:0]};
            default: value_o = bytes_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_wb_unit.sv
// ============================================================================
// mem_wb_unit : memory/write-back stage, byte-serial RAM bus, reg-file writer
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_wb_unit
    import mem_wb_unit_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid_i,
    output logic                    ex_ready_o,
    input  logic [MEM_OP_W-1:0]     ex_mem_op_i,
    input  logic                    ex_rd_enable_i,
    input  logic [REG_ADDR_LEN-1:0] ex_rd_addr_i,
    input  logic [REG_LEN-1:0]      ex_result_i,
    input  logic [REG_LEN-1:0]      ex_store_data_i,
    input  logic                    mem_grant_i,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic                    mem_wr_o,
    output logic                    mem_req_o,
    output logic [7:0]              mem_dout_o,
    input  logic [7:0]              mem_din_i,
    output logic                    rd_enable_o,
    output logic [REG_ADDR_LEN-1:0] rd_addr_o,
    output logic [REG_LEN-1:0]      rd_data_o
);

    logic [1:0]              state_q,   state_d;
    logic                    ready_q,   ready_d;
    logic [1:0]              cnt_q,     cnt_d;
    logic [1:0]              last_q,    last_d;
    logic [MEM_OP_W-1:0]     op_q,      op_d;
    logic [ADDR_W-1:0]       base_q,    base_d;
    logic [REG_LEN-1:0]      sdata_q,   sdata_d;
    logic [REG_LEN-1:0]      ld_data_q, ld_data_d;
    logic                    rx_pend_q, rx_pend_d;
    logic [1:0]              rx_lane_q, rx_lane_d;
    logic                    wr_en_q,   wr_en_d;
    logic [REG_ADDR_LEN-1:0] wr_addr_q, wr_addr_d;
    logic                    rd_en_q,   rd_en_d;
    logic [REG_ADDR_LEN-1:0] rd_addr_q, rd_addr_d;
    logic [REG_LEN-1:0]      rd_data_q, rd_data_d;

    logic [REG_LEN-1:0] w_ld_bytes;
    logic [REG_LEN-1:0] w_ld_value;
    logic               w_accept;
    logic               w_ex_wr_en;

    // The byte issued last cycle arrives now; merge it into its lane.
    always_comb begin
        w_ld_bytes = ld_data_q;
        w_ld_bytes[8*rx_lane_q +: 8] = mem_din_i;
    end

    mem_wb_unit_load_extend u_load_extend (
        .bytes_i (w_ld_bytes),
        .op_i    (op_q),
        .value_o (w_ld_value)
    );

    assign w_accept   = ex_valid_i && ready_q;
    assign w_ex_wr_en = ex_rd_enable_i && (ex_rd_addr_i != X0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            cnt_q     <= '0;
            last_q    <= '0;
            op_q      <= MEM_NONE;
            base_q    <= '0;
            sdata_q   <= '0;
            ld_data_q <= '0;
            rx_pend_q <= 1'b0;
            rx_lane_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= ZERO_WORD;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            op_q      <= op_d;
            base_q    <= base_d;
            sdata_q   <= sdata_d;
            ld_data_q <= ld_data_d;
            rx_pend_q <= rx_pend_d;
            rx_lane_q <= rx_lane_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        op_d      = op_q;
        base_d    = base_q;
        sdata_d   = sdata_q;
        ld_data_d = rx_pend_q ? w_ld_bytes : ld_data_q;
        rx_pend_d = 1'b0;
        rx_lane_d = rx_lane_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        rd_data_d = ZERO_WORD;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_load(ex_mem_op_i) || is_store(ex_mem_op_i)) begin
                        op_d      = ex_mem_op_i;
                        base_d    = ADDR_W'(ex_result_i);
                        sdata_d   = ex_store_data_i;
                        last_d    = mem_op_last(ex_mem_op_i);
                        cnt_d     = '0;
                        ld_data_d = ZERO_WORD;
                        wr_en_d   = w_ex_wr_en;
                        wr_addr_d = ex_rd_addr_i;
                        state_d   = is_load(ex_mem_op_i) ? ST_LOAD : ST_STORE;
                    end else begin
                        rd_en_d   = w_ex_wr_en;
                        rd_addr_d = w_ex_wr_en ? ex_rd_addr_i : X0;
                        rd_data_d = w_ex_wr_en ? ex_result_i : ZERO_WORD;
                    end
                end
            end
            ST_LOAD: begin
                if (mem_grant_i) begin
                    rx_pend_d = 1'b1;
                    rx_lane_d = cnt_q;
                    if (cnt_q == last_q) begin
                        state_d = ST_LOAD_TAIL;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_LOAD_TAIL: begin
                rd_en_d   = wr_en_q;
                rd_addr_d = wr_en_q ? wr_addr_q : X0;
                rd_data_d = wr_en_q ? w_ld_value : ZERO_WORD;
                state_d   = ST_IDLE;
            end
            default: begin
                if (mem_grant_i) begin
                    if (cnt_q == last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_wr_o    = 1'b0;
        mem_addr_o  = '0;
        mem_dout_o  = '0;
        if (state_q == ST_LOAD || state_q == ST_STORE) begin
            mem_req_o  = mem_grant_i;
            mem_addr_o = base_q + ADDR_W'(cnt_q);
        end
        if (state_q == ST_STORE) begin
            mem_wr_o   = 1'b1;
            mem_dout_o = sdata_q[8*cnt_q +: 8];
        end
        ex_ready_o  = ready_q;
        rd_enable_o = rd_en_q;
        rd_addr_o   = rd_addr_q;
        rd_data_o   = rd_data_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_unit.sv
// ============================================================================
// tb_mem_wb_unit : scoreboard bench with RAM responder and reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_unit;

    localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                           OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                           OP_SW = 4'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [3:0]  ex_mem_op_i = '0;
    logic        ex_rd_enable_i = 1'b0;
    logic [4:0]  ex_rd_addr_i = '0;
    logic [31:0] ex_result_i = '0;
    logic [31:0] ex_store_data_i = '0;
    logic        mem_grant_i = 1'b1;
    logic [31:0] mem_addr_o;
    logic        mem_wr_o;
    logic        mem_req_o;
    logic [7:0]  mem_dout_o;
    logic [7:0]  mem_din_i = '0;
    logic        rd_enable_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    mem_wb_unit #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid_i      (ex_valid_i),
        .ex_ready_o      (ex_ready_o),
        .ex_mem_op_i     (ex_mem_op_i),
        .ex_rd_enable_i  (ex_rd_enable_i),
        .ex_rd_addr_i    (ex_rd_addr_i),
        .ex_result_i     (ex_result_i),
        .ex_store_data_i (ex_store_data_i),
        .mem_grant_i     (mem_grant_i),
        .mem_addr_o      (mem_addr_o),
        .mem_wr_o        (mem_wr_o),
        .mem_req_o       (mem_req_o),
        .mem_dout_o      (mem_dout_o),
        .mem_din_i       (mem_din_i),
        .rd_enable_o     (rd_enable_o),
        .rd_addr_o       (rd_addr_o),
        .rd_data_o       (rd_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [31:0] addr; logic wr; logic [7:0] data; } acc_t;
    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    acc_t mem_q[$];
    wr_t  rd_q[$];

    // ram is the physical memory the DUT talks to; model_ram is the bench's belief.
    logic [7:0] ram       [logic [31:0]];
    logic [7:0] model_ram [logic [31:0]];
    logic       rand_grant  = 1'b0;
    logic       grant_force = 1'b1;
    logic       rd_pend     = 1'b0;
    logic [31:0] pend_addr  = '0;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        return model_ram.exists(a) ? model_ram[a] : dflt(a);
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        model_ram[a] = b;
    endtask

    // Expected effects of one accepted op, from the instruction semantics.
    function automatic void model(input logic [3:0] op, input logic en, input logic [4:0] ra,
                                  input logic [31:0] res, input logic [31:0] sd);
        int k;
        logic sgn, ld, st;
        logic [31:0] v;
        acc_t a;
        wr_t w;
        k = 0; sgn = 0; ld = 0; st = 0;
        case (op)
            OP_LB:  begin k = 1; sgn = 1; ld = 1; end
            OP_LBU: begin k = 1; ld = 1; end
            OP_LH:  begin k = 2; sgn = 1; ld = 1; end
            OP_LHU: begin k = 2; ld = 1; end
            OP_LW:  begin k = 4; ld = 1; end
            OP_SB:  begin k = 1; st = 1; end
            OP_SH:  begin k = 2; st = 1; end
            OP_SW:  begin k = 4; st = 1; end
            default: ;
        endcase
        w.a = ra;
        if (ld) begin
            v = 0;
            for (int i = 0; i < k; i++) begin
                a.addr = res + 32'(i); a.wr = 0; a.data = 0;
                mem_q.push_back(a);
                v = v + ({24'd0, model_rd(res + 32'(i))} << (8 * i));
            end
            if (sgn && k == 1 && v >= 32'h80)   v = v + 32'hFFFFFF00;
            if (sgn && k == 2 && v >= 32'h8000) v = v + 32'hFFFF0000;
            w.d = v;
            if (en && ra != 0) rd_q.push_back(w);
        end else if (st) begin
            for (int i = 0; i < k; i++) begin
                a.addr = res + 32'(i); a.wr = 1; a.data = 8'(sd >> (8 * i));
                mem_q.push_back(a);
                model_ram[a.addr] = a.data;
            end
        end else begin
            w.d = res;
            if (en && ra != 0) rd_q.push_back(w);
        end
    endfunction

    // RAM responder: reads answered one cycle after issue, random garbage otherwise.
    initial forever begin
        @(negedge clk);
        if (mem_req_o) begin
            if (mem_wr_o) ram[mem_addr_o] = mem_dout_o;
            else begin rd_pend = 1'b1; pend_addr = mem_addr_o; end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rd_pend) mem_din_i = ram.exists(pend_addr) ? ram[pend_addr] : dflt(pend_addr);
        else         mem_din_i = 8'($urandom);
        rd_pend = 1'b0;
        mem_grant_i = rand_grant ? ($urandom_range(0, 3) != 0) : grant_force;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a write or a bus access.
    initial begin
        wr_t  ew;
        acc_t ea;
        forever begin
            @(negedge clk);
            if (rd_enable_o) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else begin
                    ew = rd_q.pop_front();
                    chk("sb_rd_addr", 32'(rd_addr_o), 32'(ew.a));
                    chk("sb_rd_data", rd_data_o, ew.d);
                end
            end else begin
                chk("rd_data_idle", rd_data_o, 32'd0);
            end
            if (mem_req_o) begin
                if (mem_q.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
                else begin
                    ea = mem_q.pop_front();
                    chk("sb_mem_addr", mem_addr_o, ea.addr);
                    chk("sb_mem_wr", 32'(mem_wr_o), 32'(ea.wr));
                    if (ea.wr) chk("sb_mem_dout", 32'(mem_dout_o), 32'(ea.data));
                end
            end
        end
    end

    task automatic realign;
        @(posedge clk);
        #1;
    endtask

    // Presents one op; returns at posedge+1 of the cycle after the handshake.
    task automatic issue(input logic [3:0] op, input logic en, input logic [4:0] ra,
                         input logic [31:0] res, input logic [31:0] sd);
        ex_mem_op_i = op; ex_rd_enable_i = en; ex_rd_addr_i = ra;
        ex_result_i = res; ex_store_data_i = sd; ex_valid_i = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ex_ready_o) begin
                model(op, en, ra, res, sd);
                realign();
                ex_valid_i = 1'b0;
                return;
            end
        end
        chk("handshake_timeout", 32'd0, 32'd1);
        ex_valid_i = 1'b0;
    endtask

    task automatic wait_wr(input string name, input logic [4:0] ra, input logic [31:0] d);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rd_enable_o) begin
                chk({name, "_addr"}, 32'(rd_addr_o), 32'(ra));
                chk({name, "_data"}, rd_data_o, d);
                realign();
                return;
            end
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
        realign();
    endtask

    task automatic timed_load(input logic [31:0] addr, input int sc, input int sn,
                              input logic [31:0] exp);
        int wcyc, idx;
        wcyc = -1; idx = 0;
        grant_force = 1'b1;
        issue(OP_LW, 1'b1, 5'd6, addr, 32'd0);
        for (int c = 1; c <= 20 && wcyc < 0; c++) begin
            @(negedge clk);
            if (rd_enable_o) begin
                wcyc = c;
                chk("lw_data", rd_data_o, exp);
                chk("lw_ready_at_wb", 32'(ex_ready_o), 32'd1);
            end else begin
                chk("lw_ready_busy", 32'(ex_ready_o), 32'd0);
                if (sn > 0 && c >= sc && c < sc + sn) begin
                    chk("stall_no_req", 32'(mem_req_o), 32'd0);
                    chk("stall_addr_held", mem_addr_o, addr + 32'd2);
                end else if (c <= 4 + sn) begin
                    chk("lw_req", 32'(mem_req_o), 32'd1);
                    chk("lw_addr", mem_addr_o, addr + 32'(idx));
                    idx++;
                end else begin
                    chk("lw_tail_no_req", 32'(mem_req_o), 32'd0);
                end
            end
            grant_force = !(sn > 0 && c + 1 >= sc && c + 1 < sc + sn);
        end
        chk("lw_latency", 32'(wcyc), 32'(6 + sn));
        grant_force = 1'b1;
        realign();
    endtask

    initial begin
        int reads;
        logic saw;
        logic [3:0]  op;
        logic [31:0] res;
        logic [7:0]  sw_exp [4];
        sw_exp[0] = 8'hEF; sw_exp[1] = 8'hBE; sw_exp[2] = 8'hAD; sw_exp[3] = 8'hDE;

        #2 rst = 1'b0;
        #10;
        chk("reset_ready", 32'(ex_ready_o), 32'd0);
        chk("reset_rd_en", 32'(rd_enable_o), 32'd0);
        chk("reset_req", 32'(mem_req_o), 32'd0);
        chk("reset_addr", mem_addr_o, 32'd0);
        @(negedge clk); #1 rst = 1'b1;
        #1 chk("ready_before_edge", 32'(ex_ready_o), 32'd0);
        realign();
        chk("ready_after_release", 32'(ex_ready_o), 32'd1);

        // ALU write-back: one-cycle pulse in A+1.
        issue(OP_NONE, 1'b1, 5'd5, 32'h12345678, 32'd0);
        @(negedge clk);
        chk("alu_en", 32'(rd_enable_o), 32'd1);
        chk("alu_addr", 32'(rd_addr_o), 32'd5);
        chk("alu_data", rd_data_o, 32'h12345678);
        @(negedge clk);
        chk("alu_pulse_end", 32'(rd_enable_o), 32'd0);
        realign();

        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        timed_load(32'h100, 0, 0, 32'h12345678);
        timed_load(32'h100, 3, 3, 32'h12345678);

        poke(32'h300, 8'h80); poke(32'h310, 8'h01); poke(32'h311, 8'h80);
        issue(OP_LB,  1'b1, 5'd7, 32'h300, 32'd0); wait_wr("lb",  5'd7, 32'hFFFFFF80);
        issue(OP_LBU, 1'b1, 5'd8, 32'h300, 32'd0); wait_wr("lbu", 5'd8, 32'h00000080);
        issue(OP_LH,  1'b1, 5'd9, 32'h310, 32'd0); wait_wr("lh",  5'd9, 32'hFFFF8001);
        issue(OP_LHU, 1'b1, 5'd9, 32'h310, 32'd0); wait_wr("lhu", 5'd9, 32'h00008001);

        issue(OP_SW, 1'b1, 5'd3, 32'h200, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sw_wr", 32'(mem_wr_o), 32'd1);
            chk("sw_req", 32'(mem_req_o), 32'd1);
            chk("sw_addr", mem_addr_o, 32'h200 + 32'(i));
            chk("sw_byte", 32'(mem_dout_o), 32'(sw_exp[i]));
            chk("sw_no_rd", 32'(rd_enable_o), 32'd0);
        end
        @(negedge clk);
        chk("sw_done_req", 32'(mem_req_o), 32'd0);
        chk("sw_done_ready", 32'(ex_ready_o), 32'd1);
        chk("sw_done_rd", 32'(rd_enable_o), 32'd0);
        chk("sw_ram", {ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]}, 32'hDEADBEEF);
        realign();

        // Reset mid-load: outputs clear at once, unit recovers.
        issue(OP_LW, 1'b1, 5'd10, 32'h100, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_mid_req", 32'(mem_req_o), 32'd0);
        chk("rst_mid_addr", mem_addr_o, 32'd0);
        chk("rst_mid_ready", 32'(ex_ready_o), 32'd0);
        chk("rst_mid_rd", 32'(rd_enable_o), 32'd0);
        mem_q.delete();
        rd_q.delete();
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        realign();
        chk("rst_recover_ready", 32'(ex_ready_o), 32'd1);
        issue(OP_LW, 1'b1, 5'd11, 32'h100, 32'd0);
        wait_wr("lw_after_rst", 5'd11, 32'h12345678);

        // Load to x0 still reads RAM but never writes back.
        issue(OP_LW, 1'b1, 5'd0, 32'h100, 32'd0);
        reads = 0; saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req_o) reads++;
            if (rd_enable_o) saw = 1'b1;
        end
        chk("x0_reads", 32'(reads), 32'd4);
        chk("x0_no_write", 32'(saw), 32'd0);
        realign();

        rand_grant = 1'b1;
        for (int n = 0; n < 200; n++) begin
            op = 4'($urandom_range(0, 8));
            if (op == OP_NONE) res = $urandom;
            else if ($urandom_range(0, 9) == 0) res = 32'hFFFFFFFD;
            else res = 32'h400 + 32'($urandom_range(0, 31));
            issue(op, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), res, $urandom);
            repeat ($urandom_range(0, 2)) realign();
        end
        for (int n = 0; n < 100 && (mem_q.size() != 0 || rd_q.size() != 0); n++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("sb_rd_drained", 32'(rd_q.size()), 32'd0);
        chk("sb_mem_drained", 32'(mem_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
